chunked_subtractor: RTL

CHUNKED_SUBTRACTOR -- requirements
Module: chunked_subtractor

---
 rtl/chunked_subtractor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle subtractor processing CHUNK_WIDTH bits per cycle, LSB chunk first
// Optional overflow output is enabled by defining CSUB_OVERFLOW_EN.
module chunked_subtractor #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] result,
`ifdef CSUB_OVERFLOW_EN
    output logic                  borrow_out,
    output logic                  overflow
`else
    output logic                  borrow_out
`endif
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    borrow_q;
    logic [IDXW-1:0]         idx_q;
    logic                    busy_q;
    logic                    ready_q;
    logic                    borrow_out_q;

    logic [CHUNK_WIDTH-1:0]  a_chunk_d;
    logic [CHUNK_WIDTH-1:0]  b_chunk_d;
    logic [CHUNK_WIDTH:0]    diff_d;

    // The extra MSB of the widened difference is the borrow into the next chunk.
    always_comb begin
        a_chunk_d = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk_d = b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        diff_d    = {1'b0, a_chunk_d} - {1'b0, b_chunk_d} - (CHUNK_WIDTH+1)'(borrow_q);
    end

`ifdef CSUB_OVERFLOW_EN
    logic overflow_q;
    logic overflow_d;

    // Evaluated only on the last chunk, where diff_d[CHUNK_WIDTH-1] is the result sign.
    always_comb begin
        overflow_d = (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]) &
                     (diff_d[CHUNK_WIDTH-1] ^ a_q[DATA_WIDTH-1]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            borrow_q     <= 1'b0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef CSUB_OVERFLOW_EN
            overflow_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] <= diff_d[CHUNK_WIDTH-1:0];
                    borrow_q <= diff_d[CHUNK_WIDTH];
                    if (idx_q == LAST_IDX) begin
                        borrow_out_q <= diff_d[CHUNK_WIDTH];
`ifdef CSUB_OVERFLOW_EN
                        overflow_q   <= overflow_d;
`endif
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // ready is raised on the edge leaving DONE, giving NCHUNK+1 cycles of latency.
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign ready      = ready_q;
    assign result     = result_q;
    assign borrow_out = borrow_out_q;
`ifdef CSUB_OVERFLOW_EN
    assign overflow   = overflow_q;
`endif

endmodule
